// File: rtl/sentry_commit_pkg.sv
// Shared types for the sentry commit/release stage.
// Contents:
//   tag_t / data_t    instruction tag and egress payload words
//   egress_entry_t    one buffered egress record (tag + payload)
//   commit_state_e    RUN / ALERT
//   alert_cause_e     encoding reported on alert_cause
//   isCommitted       wrap-safe "tag is behind the commit point" test
package sentry_commit_pkg;

  localparam int TAG_W  = 32;
  localparam int DATA_W = 32;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    tag_t  tag;
    data_t data;
  } egress_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    ALERT = 1'b1
  } commit_state_e;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    INVALID = 2'b01,
    ORDER   = 2'b10
  } alert_cause_e;

  // A tag counts as committed when it lies strictly behind the next expected
  // tag. Taking the sign of the modular difference keeps this correct across
  // tag wrap as long as fewer than half the tag space is outstanding.
  function automatic logic isCommitted(tag_t entryTag, tag_t expectedTag);
    tag_t diff;
    diff = entryTag - expectedTag;
    return diff[TAG_W-1];
  endfunction

endpackage

// File: rtl/sentry_egress_buffer.sv
// Circular buffer holding egress records until their tag commits.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push_i, entry_i write entry_i at the tail (ignored while full)
//   pop_i           drop the head entry (ignored while empty)
//   flush_i         discard every entry; wins over push and pop
//   head_o          entry at the head (meaningful only when !empty_o)
//   full_o, empty_o occupancy flags, derived from registered pointers
module sentry_egress_buffer
  import sentry_commit_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  egress_entry_t entry_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output egress_entry_t head_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  egress_entry_t mem_q [DEPTH];
  logic doPush, doPop;

  // The extra pointer bit distinguishes full from empty when the index bits match.
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
  assign head_o  = mem_q[rdPtr_q[AW-1:0]];

  assign doPush = push_i && !full_o && !flush_i;
  assign doPop  = pop_i && !empty_o && !flush_i;

  // Pointer next-state: a flush empties the buffer by catching the read pointer up.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (flush_i) begin
      rdPtr_d = wrPtr_q;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PW'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= entry_i;
  end

endmodule

// File: rtl/sentry_commit.sv
// Commit/release stage behind the sentry checker. Pops checked tags in order,
// advances the commit point and releases buffered egress records whose tag has
// committed. Any check failure halts the stage and raises a sticky alert.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   tag, tag_valid, tag_clear     checked-tag FIFO head / not-empty / pop
//   invalid                       result mismatch reported by the checker
//   egress_valid/tag/data/ready   incoming egress records
//   out_valid/data/ready          released records (registered)
//   alert, alert_cause            sticky halt indication and its cause
//   committed_count               tags committed since reset
//   released_count                records released since reset
module sentry_commit
  import sentry_commit_pkg::*;
#(
  parameter int EGRESS_DEPTH = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  tag_t             tag,
  input  logic             tag_valid,
  output logic             tag_clear,
  input  logic             invalid,
  input  logic             egress_valid,
  input  tag_t             egress_tag,
  input  data_t            egress_data,
  output logic             egress_ready,
  output logic             out_valid,
  output data_t            out_data,
  input  logic             out_ready,
  output logic             alert,
  output logic [1:0]       alert_cause,
  output logic [CNT_W-1:0] committed_count,
  output logic [CNT_W-1:0] released_count
);

  commit_state_e    state_q, state_d;
  tag_t             expectedTag_q, expectedTag_d;
  logic             outValid_q, outValid_d;
  data_t            outData_q, outData_d;
  logic             alert_q, alert_d;
  alert_cause_e     cause_q, cause_d;
  logic [CNT_W-1:0] committedCnt_q, committedCnt_d;
  logic [CNT_W-1:0] releasedCnt_q, releasedCnt_d;

  egress_entry_t bufHead;
  egress_entry_t bufEntry;
  logic          bufFull, bufEmpty, bufPush, bufPop, bufFlush;
  logic          headCommitted, goAlert, commitPop, doRelease;

  // Handshakes are gated by reset so that nothing is offered or accepted while
  // the block is held in reset.
  assign egress_ready = rst && (state_q == RUN) && !bufFull;
  assign tag_clear    = rst && commitPop;

  assign bufEntry = '{tag: egress_tag, data: egress_data};
  assign bufPush  = egress_valid && egress_ready;
  assign bufPop   = doRelease;
  assign bufFlush = goAlert;

  assign headCommitted = isCommitted(bufHead.tag, expectedTag_q);
  assign doRelease     = (state_q == RUN) && !bufEmpty && headCommitted && (!outValid_q || out_ready);

  sentry_egress_buffer #(
    .DEPTH (EGRESS_DEPTH)
  ) u_egressBuf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bufPush),
    .entry_i (bufEntry),
    .pop_i   (bufPop),
    .flush_i (bufFlush),
    .head_o  (bufHead),
    .full_o  (bufFull),
    .empty_o (bufEmpty)
  );

  // Commit FSM: pops the tag FIFO on an in-order head, or moves to ALERT on a
  // checker mismatch or out-of-order tag. A mismatch outranks an order error.
  always_comb begin
    state_d   = state_q;
    alert_d   = alert_q;
    cause_d   = cause_q;
    goAlert   = 1'b0;
    commitPop = 1'b0;
    if (state_q == RUN) begin
      if (invalid) begin
        goAlert = 1'b1;
        cause_d = INVALID;
      end else if (tag_valid && (tag != expectedTag_q)) begin
        goAlert = 1'b1;
        cause_d = ORDER;
      end else if (tag_valid) begin
        commitPop = 1'b1;
      end
    end
    if (goAlert) begin
      state_d = ALERT;
      alert_d = 1'b1;
    end
  end

  // Commit point, output register and counters. A record already sitting in
  // the output register keeps its valid across ALERT until the sink takes it.
  always_comb begin
    expectedTag_d  = expectedTag_q;
    committedCnt_d = committedCnt_q;
    releasedCnt_d  = releasedCnt_q;
    outValid_d     = outValid_q;
    outData_d      = outData_q;
    if (commitPop) begin
      expectedTag_d  = expectedTag_q + TAG_W'(1);
      committedCnt_d = committedCnt_q + CNT_W'(1);
    end
    if (doRelease) begin
      outValid_d    = 1'b1;
      outData_d     = bufHead.data;
      releasedCnt_d = releasedCnt_q + CNT_W'(1);
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      expectedTag_q  <= '0;
      outValid_q     <= 1'b0;
      outData_q      <= '0;
      alert_q        <= 1'b0;
      cause_q        <= NONE;
      committedCnt_q <= '0;
      releasedCnt_q  <= '0;
    end else begin
      state_q        <= state_d;
      expectedTag_q  <= expectedTag_d;
      outValid_q     <= outValid_d;
      outData_q      <= outData_d;
      alert_q        <= alert_d;
      cause_q        <= cause_d;
      committedCnt_q <= committedCnt_d;
      releasedCnt_q  <= releasedCnt_d;
    end
  end

  assign out_valid       = outValid_q;
  assign out_data        = outData_q;
  assign alert           = alert_q;
  assign alert_cause     = cause_q;
  assign committed_count = committedCnt_q;
  assign released_count  = releasedCnt_q;

endmodule

// File: tb/tb_sentry_commit.sv
// Self-checking bench for sentry_commit. Directed stimulus pushes the expected
// payload of every record it expects to see released into a queue; a monitor
// pops and compares on each accepted out_valid beat.
module tb_sentry_commit;
  import sentry_commit_pkg::*;

  logic        clk;
  logic        rst;
  tag_t        tag;
  logic        tag_valid;
  logic        tag_clear;
  logic        invalid;
  logic        egress_valid;
  tag_t        egress_tag;
  data_t       egress_data;
  logic        egress_ready;
  logic        out_valid;
  data_t       out_data;
  logic        out_ready;
  logic        alert;
  logic [1:0]  alert_cause;
  logic [31:0] committed_count;
  logic [31:0] released_count;

  int    nCompared   = 0;
  int    nMismatched = 0;
  data_t expQ [$];

  sentry_commit #(
    .EGRESS_DEPTH (16),
    .CNT_W        (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .tag             (tag),
    .tag_valid       (tag_valid),
    .tag_clear       (tag_clear),
    .invalid         (invalid),
    .egress_valid    (egress_valid),
    .egress_tag      (egress_tag),
    .egress_data     (egress_data),
    .egress_ready    (egress_ready),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_ready       (out_ready),
    .alert           (alert),
    .alert_cause     (alert_cause),
    .committed_count (committed_count),
    .released_count  (released_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: compares every accepted released beat in order.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      nCompared++;
      if (expQ.size() == 0) begin
        nMismatched++;
        $display("[TB] FAIL unexpected_release: actual=%0h required=none", out_data);
      end else begin
        data_t want;
        want = expQ.pop_front();
        if (out_data !== want) begin
          nMismatched++;
          $display("[TB] FAIL release_data: actual=%0h required=%0h", out_data, want);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic tv, input tag_t t, input logic inv);
    tag_valid = tv;
    tag       = t;
    invalid   = inv;
  endtask

  task automatic doReset();
    rst          = 1'b0;
    tag_valid    = 1'b0;
    tag          = '0;
    invalid      = 1'b0;
    egress_valid = 1'b0;
    egress_tag   = '0;
    egress_data  = '0;
    out_ready    = 1'b1;
    expQ.delete();
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic pushRec(input tag_t t, input data_t d);
    egress_valid = 1'b1;
    egress_tag   = t;
    egress_data  = d;
    #1;
    checkOutput("egress_ready_on_push", egress_ready, 1'b1);
    tick();
    egress_valid = 1'b0;
  endtask

  task automatic commitRange(input tag_t first, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, first + tag_t'(i), 1'b0);
      #1;
      checkOutput("tag_clear_commit", tag_clear, 1'b1);
      tick();
    end
    tag_valid = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int cycles = 0;
    while (expQ.size() != 0 && cycles < maxCycles) begin
      tick();
      cycles++;
    end
    checkOutput("drain_remaining", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    egress_valid = 1'b0;
    egress_tag   = '0;
    egress_data  = '0;
    out_ready    = 1'b0;

    // Reset state and first record: release two cycles after the tag pop.
    doReset();
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_out_data", out_data, 64'd0);
    checkOutput("reset_alert", alert, 1'b0);
    checkOutput("reset_cause", alert_cause, 2'b00);
    checkOutput("reset_committed", committed_count, 64'd0);
    checkOutput("reset_released", released_count, 64'd0);
    checkOutput("reset_egress_ready", egress_ready, 1'b1);
    pushRec(32'd0, 32'hA5);
    applyStimulus(1'b1, 32'd0, 1'b0);
    #1;
    checkOutput("first_tag_clear", tag_clear, 1'b1);
    expQ.push_back(32'hA5);
    tick();
    tag_valid = 1'b0;
    checkOutput("first_expected_tag", dut.expectedTag_q, 64'd1);
    checkOutput("first_out_valid_n1", out_valid, 1'b0);
    tick();
    checkOutput("first_out_valid_n2", out_valid, 1'b1);
    checkOutput("first_out_data_n2", out_data, 32'hA5);
    checkOutput("first_committed", committed_count, 64'd1);
    checkOutput("first_released", released_count, 64'd1);
    waitDrain(10);

    // Late record: its tag committed before it arrived.
    doReset();
    commitRange(32'd0, 4);
    pushRec(32'd2, 32'h22);
    expQ.push_back(32'h22);
    waitDrain(10);
    checkOutput("late_released", released_count, 64'd1);
    checkOutput("late_committed", committed_count, 64'd4);

    // Back-pressure: full buffer, held output, then one release per cycle.
    doReset();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) pushRec(tag_t'(i), data_t'(32'h100 + i));
    checkOutput("bp_full_not_ready", egress_ready, 1'b0);
    commitRange(32'd0, 16);
    tick();
    tick();
    checkOutput("bp_held_valid", out_valid, 1'b1);
    checkOutput("bp_held_data", out_data, 32'h100);
    checkOutput("bp_held_released", released_count, 64'd1);
    checkOutput("bp_committed", committed_count, 64'd16);
    for (int i = 0; i < 16; i++) expQ.push_back(data_t'(32'h100 + i));
    out_ready = 1'b1;
    repeat (15) tick();
    checkOutput("bp_back_to_back", released_count, 64'd16);
    tick();
    checkOutput("bp_out_valid_done", out_valid, 1'b0);
    checkOutput("bp_ready_again", egress_ready, 1'b1);
    waitDrain(4);

    // Tag wrap: commit point preloaded just below the top of the tag space.
    doReset();
    force dut.expectedTag_q = 32'hFFFF_FFFE;
    #1;
    release dut.expectedTag_q;
    pushRec(32'hFFFF_FFFF, 32'hEE1);
    pushRec(32'h0000_0000, 32'hEE2);
    tick();
    checkOutput("wrap_not_early", out_valid, 1'b0);
    expQ.push_back(32'hEE1);
    expQ.push_back(32'hEE2);
    commitRange(32'hFFFF_FFFE, 3);
    waitDrain(10);
    checkOutput("wrap_released", released_count, 64'd2);
    checkOutput("wrap_committed", committed_count, 64'd3);

    // Order error: expected 5, offered 7.
    doReset();
    commitRange(32'd0, 5);
    pushRec(32'd9, 32'h99);
    applyStimulus(1'b1, 32'd7, 1'b0);
    #1;
    checkOutput("order_no_pop", tag_clear, 1'b0);
    tick();
    tag_valid = 1'b0;
    checkOutput("order_alert", alert, 1'b1);
    checkOutput("order_cause", alert_cause, 2'b10);
    checkOutput("order_egress_ready", egress_ready, 1'b0);
    checkOutput("order_buf_empty", dut.bufEmpty, 1'b1);
    checkOutput("order_committed", committed_count, 64'd5);
    tick();
    tick();
    checkOutput("order_alert_sticky", alert, 1'b1);
    checkOutput("order_no_release", out_valid, 1'b0);

    // Invalid together with an order error, then reset while in ALERT.
    doReset();
    out_ready = 1'b0;
    pushRec(32'd0, 32'h66);
    commitRange(32'd0, 1);
    tick();
    checkOutput("inv_held_valid", out_valid, 1'b1);
    applyStimulus(1'b1, 32'd5, 1'b1);
    #1;
    checkOutput("inv_no_pop", tag_clear, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("inv_alert", alert, 1'b1);
    checkOutput("inv_cause", alert_cause, 2'b01);
    checkOutput("inv_out_kept", out_valid, 1'b1);
    checkOutput("inv_out_data_kept", out_data, 32'h66);
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_data", out_data, 64'd0);
    checkOutput("rst_alert", alert, 1'b0);
    checkOutput("rst_cause", alert_cause, 2'b00);
    checkOutput("rst_committed", committed_count, 64'd0);
    checkOutput("rst_released", released_count, 64'd0);
    checkOutput("rst_egress_ready", egress_ready, 1'b0);
    checkOutput("rst_tag_clear", tag_clear, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("rerun_egress_ready", egress_ready, 1'b1);
    out_ready = 1'b1;
    commitRange(32'd0, 1);
    checkOutput("rerun_committed", committed_count, 64'd1);
    checkOutput("rerun_alert", alert, 1'b0);

    waitDrain(10);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
